puf_ro_reader: RTL and testbench

Measurement engine for the configurable ring-oscillator PUF. On a request it drives a 6-bit challenge and the RO enable to two ring-oscillator instances (A and B), synchronizes their free-running outputs, and counts rising edges over a fixed window. It then compares the two counts to produce one response bit with a valid pulse. It sits between the challenge source (test harness or key-generation controller) and the RO pair.

---
 rtl/puf_ro_reader.sv | 191 +++++++++++++++++++
 tb/tb_puf_ro_reader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/puf_ro_reader.sv
// Ring-oscillator PUF measurement engine: counts synchronized RO edges over a window and compares A vs B.
// Optional PUF_MAJORITY_VOTE_EN: three back-to-back measurements, response is the majority bit.
module puf_ro_reader #(
  parameter int CNT_W       = 16,
  parameter int WINDOW      = 1024,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       challenge_in,
  output logic             busy,
  output logic             ro_en,
  output logic [5:0]       ro_challenge,
  input  logic             ro_a,
  input  logic             ro_b,
  output logic             resp,
  output logic             resp_valid,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SETTLE = 3'd1;
  localparam logic [2:0] RUN    = 3'd2;
  localparam logic [2:0] DRAIN  = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  localparam int TW = $clog2(WINDOW + SYNC_STAGES + 4);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

`ifdef PUF_MAJORITY_VOTE_EN
  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction
`endif

  logic [2:0]             state_q, state_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [5:0]             chal_q, chal_d;
  logic [CNT_W-1:0]       cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic [CNT_W-1:0]       cnt_a_inc, cnt_b_inc;
  logic [SYNC_STAGES-1:0] sync_a_q, sync_b_q;
  logic                   dly_a_q, dly_b_q;
  logic                   busy_q, ro_en_q, resp_q, resp_d, resp_valid_q;
  logic                   clr_s, counting_s, rise_a_s, rise_b_s, a_gt_b_s;
`ifdef PUF_MAJORITY_VOTE_EN
  logic [1:0]             run_q, run_d;
  logic [1:0]             bits_q, bits_d;
`endif

  assign counting_s = (state_q == RUN) || (state_q == DRAIN);
  assign rise_a_s   = sync_a_q[SYNC_STAGES-1] & ~dly_a_q;
  assign rise_b_s   = sync_b_q[SYNC_STAGES-1] & ~dly_b_q;
  assign cnt_a_inc  = (counting_s && rise_a_s) ? sat_inc(cnt_a_q) : cnt_a_q;
  assign cnt_b_inc  = (counting_s && rise_b_s) ? sat_inc(cnt_b_q) : cnt_b_q;
  // Compare the counts including an increment landing on the final DRAIN edge.
  assign a_gt_b_s   = cnt_a_inc > cnt_b_inc;
  assign cnt_a_d    = clr_s ? {CNT_W{1'b0}} : cnt_a_inc;
  assign cnt_b_d    = clr_s ? {CNT_W{1'b0}} : cnt_b_inc;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    chal_d  = chal_q;
    clr_s   = 1'b0;
    resp_d  = resp_q;
`ifdef PUF_MAJORITY_VOTE_EN
    run_d   = run_q;
    bits_d  = bits_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETTLE;
          timer_d = TW'(3);
          chal_d  = challenge_in;
          clr_s   = 1'b1;
`ifdef PUF_MAJORITY_VOTE_EN
          run_d   = 2'd0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      SETTLE: begin
        if (timer_q == '0) begin
          state_d = RUN;
          timer_d = TW'(WINDOW - 1);
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      RUN: begin
        if (timer_q == '0) begin
          state_d = DRAIN;
          timer_d = TW'(SYNC_STAGES + 1);
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      DRAIN: begin
        if (timer_q == '0) begin
`ifdef PUF_MAJORITY_VOTE_EN
          if (run_q == 2'd2) begin
            state_d = DONE;
            resp_d  = maj3(bits_q[0], bits_q[1], a_gt_b_s);
          end else begin
            bits_d[run_q[0]] = a_gt_b_s;
            run_d   = run_q + 2'd1;
            state_d = SETTLE;
            timer_d = TW'(3);
            clr_s   = 1'b1;
          end
`else
          state_d = DONE;
          resp_d  = a_gt_b_s;
`endif
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      chal_q       <= 6'd0;
      cnt_a_q      <= '0;
      cnt_b_q      <= '0;
      busy_q       <= 1'b0;
      ro_en_q      <= 1'b0;
      resp_q       <= 1'b0;
      resp_valid_q <= 1'b0;
`ifdef PUF_MAJORITY_VOTE_EN
      run_q        <= 2'd0;
      bits_q       <= 2'd0;
`endif
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      chal_q       <= chal_d;
      cnt_a_q      <= cnt_a_d;
      cnt_b_q      <= cnt_b_d;
      busy_q       <= (state_d == SETTLE) || (state_d == RUN) || (state_d == DRAIN);
      ro_en_q      <= (state_d == RUN);
      resp_q       <= resp_d;
      resp_valid_q <= (state_d == DONE);
`ifdef PUF_MAJORITY_VOTE_EN
      run_q        <= run_d;
      bits_q       <= bits_d;
`endif
    end
  end

  // RO synchronizers followed by the edge-detect delay register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a_q <= '0;
      sync_b_q <= '0;
      dly_a_q  <= 1'b0;
      dly_b_q  <= 1'b0;
    end else begin
      sync_a_q <= {sync_a_q[SYNC_STAGES-2:0], ro_a};
      sync_b_q <= {sync_b_q[SYNC_STAGES-2:0], ro_b};
      dly_a_q  <= sync_a_q[SYNC_STAGES-1];
      dly_b_q  <= sync_b_q[SYNC_STAGES-1];
    end
  end

  assign busy         = busy_q;
  assign ro_en        = ro_en_q;
  assign ro_challenge = chal_q;
  assign resp         = resp_q;
  assign resp_valid   = resp_valid_q;
  assign cnt_a        = cnt_a_q;
  assign cnt_b        = cnt_b_q;

endmodule

// File: tb/tb_puf_ro_reader.sv
// Scoreboard bench for puf_ro_reader: a 16-bit and a 4-bit (saturating) instance, WINDOW=64.
module tb_puf_ro_reader;

`ifdef PUF_MAJORITY_VOTE_EN
  localparam int LAT = 216;
`else
  localparam int LAT = 72;
`endif

  typedef struct {
    logic       r;
    int         alo, ahi, blo, bhi;
    logic [5:0] ch;
    int         cyc;
  } exp_t;

  exp_t q[$];
  exp_t qs[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, start_s = 1'b0;
  logic [5:0] challenge_in = 6'd0, challenge_s = 6'd0;
  logic ro_a = 1'b0, ro_b = 1'b0, sro_a = 1'b0, sro_b = 1'b0;
  logic busy, ro_en, resp, resp_valid;
  logic [5:0] ro_challenge;
  logic [15:0] cnt_a, cnt_b;
  logic sbusy, sro_en, sresp, sresp_valid;
  logic [5:0] sro_challenge;
  logic [3:0] scnt_a, scnt_b;
  int pa = 8, pb = 16, spa = 2, spb = 0;

  puf_ro_reader #(.CNT_W(16), .WINDOW(64), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .challenge_in(challenge_in),
    .busy(busy), .ro_en(ro_en), .ro_challenge(ro_challenge),
    .ro_a(ro_a), .ro_b(ro_b), .resp(resp), .resp_valid(resp_valid),
    .cnt_a(cnt_a), .cnt_b(cnt_b));

  puf_ro_reader #(.CNT_W(4), .WINDOW(64), .SYNC_STAGES(2)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .challenge_in(challenge_s),
    .busy(sbusy), .ro_en(sro_en), .ro_challenge(sro_challenge),
    .ro_a(sro_a), .ro_b(sro_b), .resp(sresp), .resp_valid(sresp_valid),
    .cnt_a(scnt_a), .cnt_b(scnt_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d..%0d", nm, act, lo, hi);
    end
  endtask

  function automatic logic ro_wave(input int ph, input int p);
    return (p == 0) ? 1'b0 : ((ph % p) < (p / 2));
  endfunction

  // RO models: free-running only while ro_en is high, held low otherwise.
  initial begin
    int ph = 0, sph = 0;
    forever begin
      @(negedge clk);
      if (!ro_en) begin ph = 0; ro_a = 1'b0; ro_b = 1'b0; end
      else begin ro_a = ro_wave(ph, pa); ro_b = ro_wave(ph, pb); ph++; end
      if (!sro_en) begin sph = 0; sro_a = 1'b0; sro_b = 1'b0; end
      else begin sro_a = ro_wave(sph, spa); sro_b = ro_wave(sph, spb); sph++; end
    end
  end

  // Monitor: every resp_valid must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resp_valid) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_resp_valid actual=1 expected=0 cyc=%0d", cyc);
        end else begin
          e = q.pop_front();
          chk("resp", int'(resp), int'(e.r));
          chk_rng("cnt_a", int'(cnt_a), e.alo, e.ahi);
          chk_rng("cnt_b", int'(cnt_b), e.blo, e.bhi);
          chk("ro_challenge", int'(ro_challenge), int'(e.ch));
          chk("valid_cycle", cyc, e.cyc);
        end
      end
      if (sresp_valid) begin
        if (qs.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_sat_resp_valid actual=1 expected=0 cyc=%0d", cyc);
        end else begin
          e = qs.pop_front();
          chk("sat_resp", int'(sresp), int'(e.r));
          chk_rng("sat_cnt_a", int'(scnt_a), e.alo, e.ahi);
          chk_rng("sat_cnt_b", int'(scnt_b), e.blo, e.bhi);
          chk("sat_valid_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic go(input logic [5:0] ch, output int k);
    @(negedge clk);
    start = 1'b1;
    challenge_in = ch;
    @(negedge clk);
    k = cyc;
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
  endtask

  task automatic push(input logic r, input int alo, input int ahi, input int blo,
                      input int bhi, input logic [5:0] ch, input int c);
    exp_t e;
    e.r = r; e.alo = alo; e.ahi = ahi; e.blo = blo; e.bhi = bhi; e.ch = ch; e.cyc = c;
    q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || qs.size() != 0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0 || qs.size() != 0) begin
      total++; bad++;
      $display("FAIL timeout_resp_valid actual=%0d expected=0 pending", q.size() + qs.size());
    end
    repeat (5) @(negedge clk);
  endtask

  initial begin
    int k;
    exp_t e;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ro_en", int'(ro_en), 0);
    chk("rst_cnt_a", int'(cnt_a), 0);
    chk("rst_resp_valid", int'(resp_valid), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // A faster than B; extra starts during RUN and DONE must be ignored.
    pa = 8; pb = 16;
    go(6'h2A, k);
    push(1'b1, 7, 9, 3, 5, 6'h2A, k + LAT);
    wait_until(k + 3);
    chk("ro_en_settle", int'(ro_en), 0);
    wait_until(k + 4);
    chk("ro_en_rise", int'(ro_en), 1);
    chk("ro_challenge_out", int'(ro_challenge), 8'h2A);
    wait_until(k + 30);
    start = 1'b1; challenge_in = 6'h15;
    @(negedge clk);
    start = 1'b0;
    wait_until(k + 67);
    chk("ro_en_last", int'(ro_en), 1);
    wait_until(k + 68);
    chk("ro_en_fall", int'(ro_en), 0);
    wait_until(k + LAT);
    start = 1'b1; challenge_in = 6'h33;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("busy_after_done_start", int'(busy), 0);
    chk("ro_challenge_held", int'(ro_challenge), 8'h2A);
    drain();

    // Swapped ROs.
    pa = 16; pb = 8;
    go(6'h01, k);
    push(1'b0, 3, 5, 7, 9, 6'h01, k + LAT);
    drain();

    // Equal periods: tie resolves to 0.
    pa = 8; pb = 8;
    go(6'h3F, k);
    push(1'b0, 8, 8, 8, 8, 6'h3F, k + LAT);
    drain();

    // Reset in the middle of RUN after a resp=1 run.
    pa = 8; pb = 16;
    go(6'h2A, k);
    push(1'b1, 7, 9, 3, 5, 6'h2A, k + LAT);
    drain();
    go(6'h0C, k);
    wait_until(k + 20);
    chk("ro_en_mid_run", int'(ro_en), 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_ro_en", int'(ro_en), 0);
    chk("rst_async_busy", int'(busy), 0);
    chk("rst_async_cnt_a", int'(cnt_a), 0);
    chk("rst_async_resp", int'(resp), 0);
    chk("rst_async_chal", int'(ro_challenge), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    go(6'h2A, k);
    push(1'b1, 7, 9, 3, 5, 6'h2A, k + LAT);
    drain();

`ifdef PUF_MAJORITY_VOTE_EN
    // Run 2 has B faster; majority still favours A.
    pa = 8; pb = 16;
    go(6'h11, k);
    push(1'b1, 7, 9, 3, 5, 6'h11, k + 216);
    wait_until(k + 73);
    chk("busy_between_runs", int'(busy), 1);
    pa = 16; pb = 8;
    wait_until(k + 145);
    pa = 8; pb = 16;
    drain();
`endif

    // Saturating 4-bit instance with B stopped.
    @(negedge clk);
    start_s = 1'b1; challenge_s = 6'h05;
    @(negedge clk);
    k = cyc;
    start_s = 1'b0;
    e.r = 1'b1; e.alo = 15; e.ahi = 15; e.blo = 0; e.bhi = 0; e.ch = 6'h05; e.cyc = k + LAT;
    qs.push_back(e);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
